// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with valid flag and one-cycle latency.
// Optional one-hot violation flag `err` is built only when ONEHOT_CHECK_EN is defined.
module encoder_8to3 #(
    parameter bit         PRIORITY_MSB = 1'b1,
    parameter logic [2:0] ZERO_CODE    = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       valid
`ifdef ONEHOT_CHECK_EN
    ,
    output logic       err
`endif
);

    logic [2:0] out_q, out_d;
    logic       valid_q, valid_d;

    // Later (higher) set bits overwrite earlier ones, so the highest index wins.
    function automatic logic [2:0] enc_msb(input logic [7:0] v);
        logic [2:0] idx;
        idx = ZERO_CODE;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] enc_lsb(input logic [7:0] v);
        logic [2:0] idx;
        idx = ZERO_CODE;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        valid_d = |in;
        out_d   = PRIORITY_MSB ? enc_msb(in) : enc_lsb(in);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= ZERO_CODE;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

`ifdef ONEHOT_CHECK_EN
    logic err_q, err_d;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    always_comb begin
        err_d = |(in & (in - 8'd1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed bench for encoder_8to3: an MSB-priority instance (ZERO_CODE=000) and an
// LSB-priority instance (ZERO_CODE=101) driven by the same stimulus.
module tb_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic [2:0] out_m, out_l;
    logic       valid_m, valid_l;
`ifdef ONEHOT_CHECK_EN
    logic       err_m, err_l;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    encoder_8to3 #(.PRIORITY_MSB(1'b1), .ZERO_CODE(3'b000)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out_m),
        .valid (valid_m)
`ifdef ONEHOT_CHECK_EN
        ,
        .err   (err_m)
`endif
    );

    encoder_8to3 #(.PRIORITY_MSB(1'b0), .ZERO_CODE(3'b101)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out_l),
        .valid (valid_l)
`ifdef ONEHOT_CHECK_EN
        ,
        .err   (err_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare both instances against hand-computed values (e = expected err).
    task automatic chk_all(input string tag, input logic [2:0] em, input logic [2:0] el,
                           input logic ev, input logic e);
        chk({tag, ".out_msb"}, 8'(out_m), 8'(em));
        chk({tag, ".out_lsb"}, 8'(out_l), 8'(el));
        chk({tag, ".valid_msb"}, 8'(valid_m), 8'(ev));
        chk({tag, ".valid_lsb"}, 8'(valid_l), 8'(ev));
`ifdef ONEHOT_CHECK_EN
        chk({tag, ".err_msb"}, 8'(err_m), 8'(e));
        chk({tag, ".err_lsb"}, 8'(err_l), 8'(e));
`else
        if (e) begin end
`endif
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] v;
        logic [2:0] em;
        logic [2:0] el;
        logic       ev;
        logic       e;
    } vec_t;

    vec_t lat[9];

    initial begin
        lat[0] = '{8'h81, 3'd7, 3'd0, 1'b1, 1'b1};
        lat[1] = '{8'h18, 3'd4, 3'd3, 1'b1, 1'b1};
        lat[2] = '{8'h02, 3'd1, 3'd1, 1'b1, 1'b0};
        lat[3] = '{8'h7E, 3'd6, 3'd1, 1'b1, 1'b1};
        lat[4] = '{8'h00, 3'd0, 3'd5, 1'b0, 1'b0};
        lat[5] = '{8'hC0, 3'd7, 3'd6, 1'b1, 1'b1};
        lat[6] = '{8'h10, 3'd4, 3'd4, 1'b1, 1'b0};
        lat[7] = '{8'h55, 3'd6, 3'd0, 1'b1, 1'b1};
        lat[8] = '{8'h20, 3'd5, 3'd5, 1'b1, 1'b0};

        // Reset held for two edges with all requests active.
        rst_n = 1'b0;
        in    = 8'hFF;
        tick();
        chk_all("rst1", 3'd0, 3'd5, 1'b0, 1'b0);
        tick();
        chk_all("rst2", 3'd0, 3'd5, 1'b0, 1'b0);

        rst_n = 1'b1;
        tick();
        chk_all("rel_ff", 3'd7, 3'd0, 1'b1, 1'b1);

        // One-hot sweep.
        for (int k = 0; k < 8; k++) begin
            in = 8'(1 << k);
            tick();
            chk_all($sformatf("onehot%0d", k), 3'(k), 3'(k), 1'b1, 1'b0);
        end

        in = 8'h00;
        tick();
        chk_all("zero", 3'd0, 3'd5, 1'b0, 1'b0);

        in = 8'b0010_0110;
        tick();
        chk_all("multi", 3'd5, 3'd1, 1'b1, 1'b1);

        // Mid-stream reset.
        in = 8'b0100_0000;
        tick();
        chk_all("pre_rst", 3'd6, 3'd6, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_all("mid_rst", 3'd0, 3'd5, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("post_rst", 3'd6, 3'd6, 1'b1, 1'b0);

        // Latency: in changes every cycle; outputs must follow only the sampled value.
        for (int i = 0; i < 9; i++) begin
            in = lat[i].v;
            tick();
            chk_all($sformatf("lat%0d", i), lat[i].em, lat[i].el, lat[i].ev, lat[i].e);
            in = lat[(i + 1) % 9].v;
            #2;
            chk_all($sformatf("hold%0d", i), lat[i].em, lat[i].el, lat[i].ev, lat[i].e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
